// File: rtl/jtopl_snd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_snd_pkg
// Purpose  : Shared widths, saturation limits and the sample type used by
//            the sound output FIFO and its gain/saturation stage.
// Contents : SND_W, SND_MAX, SND_MIN, DROP_W, snd_t
// Revision : 1.0 - initial release
// ============================================================================
package jtopl_snd_pkg;

  localparam int SND_W  = 16;
  localparam int DROP_W = 8;

  typedef logic signed [SND_W-1:0] snd_t;

  localparam snd_t SND_MAX = 16'sh7FFF;
  localparam snd_t SND_MIN = 16'sh8000;

endpackage : jtopl_snd_pkg
`default_nettype wire

// File: rtl/jtopl_snd_sat.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_snd_sat
// Purpose  : Combinational arithmetic left shift of a signed sample by 0..3
//            places, saturating the result to the 16-bit signed range.
// Ports    : snd  (in)  signed input sample
//            gain (in)  shift amount 0..3
//            out  (out) shifted, saturated sample
//            sat  (out) high when the result was clamped
// Revision : 1.0 - initial release
// ============================================================================
module jtopl_snd_sat
  import jtopl_snd_pkg::*;
(
  input  snd_t       snd,
  input  logic [1:0] gain,
  output snd_t       out,
  output logic       sat
);

  // Three guard bits hold the largest possible shift without loss.
  logic signed [SND_W+2:0] w_ext;
  logic signed [SND_W+2:0] w_shifted;
  logic                    w_fits;

  assign w_ext     = {{3{snd[SND_W-1]}}, snd};
  assign w_shifted = w_ext <<< gain;

  // The value fits in 16 bits when the guard bits all match the new sign bit.
  assign w_fits = (w_shifted[SND_W+2:SND_W-1] == 4'b0000) ||
                  (w_shifted[SND_W+2:SND_W-1] == 4'b1111);

  always_comb begin
    out = w_shifted[SND_W-1:0];
    sat = 1'b0;
    if (!w_fits) begin
      sat = 1'b1;
      out = w_shifted[SND_W+2] ? SND_MIN : SND_MAX;
    end
  end

endmodule : jtopl_snd_sat
`default_nettype wire

// File: rtl/jtopl_snd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_snd_fifo
// Purpose  : Captures one signed sample per sample strobe into a small FIFO
//            and presents it on a valid/ready stream to the audio consumer.
//            Samples arriving while the FIFO is full (and not draining) are
//            dropped, signalled by ovf and counted in drops.
// Options  : JTOPL_SND_GAIN_EN - adds the gain input and the sticky clip
//            output; incoming samples are shifted left by gain and saturated.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            snd, sample         input sample and its one-clock strobe
//            gain                shift amount (JTOPL_SND_GAIN_EN only)
//            out_data/valid/ready output stream
//            level               occupancy 0..DEPTH
//            ovf                 one-clock pulse per dropped sample
//            drops               saturating drop counter
//            clip                sticky saturation flag (JTOPL_SND_GAIN_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module jtopl_snd_fifo
  import jtopl_snd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  snd_t              snd,
  input  logic              sample,
`ifdef JTOPL_SND_GAIN_EN
  input  logic [1:0]        gain,
  output logic              clip,
`endif
  output snd_t              out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       level,
  output logic              ovf,
  output logic [DROP_W-1:0] drops
);

  localparam logic [AW:0]       c_FULL     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]     c_PTR_ONE  = AW'(1);
  localparam logic [DROP_W-1:0] c_DROP_MAX = '1;

  snd_t              r_ram [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_out_valid;
  snd_t              r_out_data;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drops;

  snd_t              w_wdata;
  logic              w_sat;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AW-1:0]     w_rd_next;
  logic [AW:0]       w_level_next;
  snd_t              w_head_next;

`ifdef JTOPL_SND_GAIN_EN
  logic r_clip;

  jtopl_snd_sat u_sat (
    .snd  (snd),
    .gain (gain),
    .out  (w_wdata),
    .sat  (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip <= 1'b0;
    end else if (w_push && w_sat) begin
      r_clip <= 1'b1;
    end
  end

  assign clip = r_clip;
`else
  assign w_wdata = snd;
  assign w_sat   = 1'b0;
`endif

  assign w_full = (r_level == c_FULL);
  assign w_pop  = r_out_valid && out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_push = sample && (!w_full || w_pop);
  assign w_drop = sample && w_full && !w_pop;

  assign w_rd_next = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  // The output register is loaded with the next head entry. When the slot
  // being written this cycle becomes the head (empty FIFO, or push+pop at
  // level 1) the RAM has not been updated yet, so bypass the write data.
  always_comb begin
    w_head_next = r_ram[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ram[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
      r_drops     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      r_rd_ptr    <= w_rd_next;
      r_level     <= w_level_next;
      r_out_valid <= (w_level_next != '0);
      // Hold the last value when draining to empty; nothing reads it then.
      if (w_level_next != '0) begin
        r_out_data <= w_head_next;
      end
      r_ovf <= w_drop;
      if (w_drop && (r_drops != c_DROP_MAX)) begin
        r_drops <= r_drops + 1'b1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign ovf       = r_ovf;
  assign drops     = r_drops;

endmodule : jtopl_snd_fifo
`default_nettype wire
